// File: rtl/core_pkg.sv
// Shared definitions for the multi-cycle RV32I core: sequencer states,
// major-opcode constants used by the executor and decoder, reset defaults.
package core_pkg;

  typedef enum logic [2:0] {
    ST_FETCH = 3'd0,
    ST_EXEC  = 3'd1,
    ST_MEM   = 3'd2,
    ST_WB    = 3'd3,
    ST_FAULT = 3'd4
  } state_t;

  // Major opcodes, instruction bits [6:2]
  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_OPIMM  = 5'b00100;
  localparam logic [4:0] OP_OP     = 5'b01100;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/core_sequencer_if.sv
// Shared memory bus between the core sequencer (master) and memory (slave).
interface core_sequencer_if;
  import core_pkg::*;

  logic        memory_wait;
  logic [31:0] memory_read_data;
  logic [31:0] bus_address;
  logic [31:0] bus_write_data;
  logic        bus_read;
  logic        bus_write;

  modport master (
    input  memory_wait,
    input  memory_read_data,
    output bus_address,
    output bus_write_data,
    output bus_read,
    output bus_write
  );

  modport slave (
    output memory_wait,
    output memory_read_data,
    input  bus_address,
    input  bus_write_data,
    input  bus_read,
    input  bus_write
  );

endinterface

// File: rtl/core_sequencer_bus_timer.sv
// Counts consecutive stalled cycles of one bus access and flags the cycle
// in which the stall budget is used up.
module bus_timer
  import core_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [W-1:0] LAST_COUNT = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] r_count;

  // The stall that would push the count to TIMEOUT_CYCLES is the expiring one
  assign expired = enable && (r_count == LAST_COUNT);

  // Wait-cycle counter; clear has priority so a completed access starts fresh
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (enable && !expired) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle control FSM of the RV32I core. Owns PC, instruction and load
// registers, arbitrates the single memory bus between fetch and load/store,
// gates register-file writes, counts retirements and halts on bus timeout.
module core_sequencer
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = DEFAULT_RESET_PC,
  parameter int          TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  core_sequencer_if.master   bus,
  input  logic [31:0]        ex_pc_next,
  input  logic [31:0]        ex_mem_address,
  input  logic [31:0]        ex_mem_write_data,
  input  logic               ex_mem_read,
  input  logic               ex_mem_write,
  input  logic               ex_rd_write,
  output logic [31:0]        pc,
  output logic [31:0]        instr,
  output logic [31:0]        load_data,
  output logic               rf_write_en,
  output logic [31:0]        instret,
  output logic               bus_fault
);

  state_t      r_state;
  state_t      w_nextState;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_loadData;
  logic [31:0] r_instret;
  logic        r_busFault;
  logic        r_memStore;

  logic        w_request;
  logic        w_stall;
  logic        w_complete;
  logic        w_timerExpired;
  logic        w_busRead;
  logic        w_busWrite;
  logic [31:0] w_busAddress;
  logic [31:0] w_busWriteData;
  logic        w_rfWriteEn;

  // Request is derived from state only so the timer does not loop back
  // through the output decode
  assign w_request  = (r_state == ST_FETCH) || (r_state == ST_MEM);
  assign w_stall    = w_request && bus.memory_wait;
  assign w_complete = w_request && !bus.memory_wait;

  bus_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_bus_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (!w_stall),
    .enable (w_stall),
    .expired(w_timerExpired)
  );

  // Next-state and bus/strobe decode; idle bus drives zeros
  always_comb begin
    w_nextState    = r_state;
    w_busRead      = 1'b0;
    w_busWrite     = 1'b0;
    w_busAddress   = '0;
    w_busWriteData = '0;
    w_rfWriteEn    = 1'b0;
    case (r_state)
      ST_FETCH: begin
        w_busRead    = 1'b1;
        w_busAddress = r_pc;
        if (w_timerExpired) begin
          w_nextState = ST_FAULT;
        end else if (!bus.memory_wait) begin
          w_nextState = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (ex_mem_write || ex_mem_read) begin
          w_nextState = ST_MEM;
        end else begin
          w_nextState = ST_WB;
        end
      end
      ST_MEM: begin
        w_busAddress = ex_mem_address;
        if (r_memStore) begin
          w_busWrite     = 1'b1;
          w_busWriteData = ex_mem_write_data;
        end else begin
          w_busRead = 1'b1;
        end
        if (w_timerExpired) begin
          w_nextState = ST_FAULT;
        end else if (!bus.memory_wait) begin
          w_nextState = ST_WB;
        end
      end
      ST_WB: begin
        w_rfWriteEn = ex_rd_write;
        w_nextState = ST_FETCH;
      end
      ST_FAULT: begin
        w_nextState = ST_FAULT;
      end
      default: begin
        w_nextState = ST_FAULT;
      end
    endcase
  end

  // Requests are also gated by reset so an access dies the instant reset hits
  assign bus.bus_read       = w_busRead && rst_n;
  assign bus.bus_write      = w_busWrite && rst_n;
  assign bus.bus_address    = rst_n ? w_busAddress : '0;
  assign bus.bus_write_data = rst_n ? w_busWriteData : '0;
  assign rf_write_en        = w_rfWriteEn && rst_n;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_FETCH;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Architectural registers: updated only on completed accesses and retirement
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc       <= RESET_PC;
      r_instr    <= '0;
      r_loadData <= '0;
      r_instret  <= '0;
      r_busFault <= 1'b0;
      r_memStore <= 1'b0;
    end else begin
      case (r_state)
        ST_FETCH: begin
          if (w_complete) begin
            r_instr <= bus.memory_read_data;
          end
        end
        ST_EXEC: begin
          r_memStore <= ex_mem_write;
        end
        ST_MEM: begin
          if (w_complete && !r_memStore) begin
            r_loadData <= bus.memory_read_data;
          end
        end
        ST_WB: begin
          r_pc      <= ex_pc_next;
          r_instret <= r_instret + 32'd1;
        end
        default: begin
        end
      endcase
      if (w_nextState == ST_FAULT) begin
        r_busFault <= 1'b1;
      end
    end
  end

  assign pc        = r_pc;
  assign instr     = r_instr;
  assign load_data = r_loadData;
  assign instret   = r_instret;
  assign bus_fault = r_busFault;

endmodule
